// File: rtl/halfword_packer_if.sv
// Valid/ready bus for halfword_packer: 16-bit producer side in, 32-bit consumer side out.
// PACKER_PARITY_EN adds out_parity alongside out_data.
interface halfword_packer_if #(
  parameter int HALF_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [HALF_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*HALF_W-1:0]   out_data;
  logic [7:0]            out_count;
`ifdef PACKER_PARITY_EN
  logic                  out_parity;
`endif

  // Packer side of the bus.
  modport slave (
`ifdef PACKER_PARITY_EN
    output out_parity,
`endif
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_count
  );

  // Producer/consumer side of the bus.
  modport master (
`ifdef PACKER_PARITY_EN
    input  out_parity,
`endif
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_count
  );
endinterface

// File: rtl/halfword_packer.sv
// Packs two successive halfwords (low first) into one word on a valid/ready port.
// Optional PACKER_PARITY_EN registers the XOR-reduction of each packed word.
module halfword_packer #(
  parameter int HALF_W = 16
) (
  input logic               clock,
  input logic               reset_n,
  input logic               flush,
  halfword_packer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HAVE_LO = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t                r_state;
  logic [HALF_W-1:0]     r_lo;
  logic [2*HALF_W-1:0]   r_out_data;
  logic                  r_out_valid;
  logic [7:0]            r_out_count;
`ifdef PACKER_PARITY_EN
  logic                  r_out_parity;
`endif

  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [2*HALF_W-1:0]   w_word;

  // A full word may drain and a new low half be captured on the same edge,
  // which is what keeps the input stream free of bubbles.
  assign w_in_ready = !flush && ((r_state != ST_FULL) || bus.out_ready);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;
  assign w_word     = {bus.in_data, r_lo};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_EMPTY;
      r_lo        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= 8'd0;
`ifdef PACKER_PARITY_EN
      r_out_parity <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_lo    <= bus.in_data;
            r_state <= ST_HAVE_LO;
          end
        end

        ST_HAVE_LO: begin
          if (flush) begin
            r_state <= ST_EMPTY;
          end else if (w_in_fire) begin
            r_out_data  <= w_word;
            r_out_valid <= 1'b1;
`ifdef PACKER_PARITY_EN
            r_out_parity <= ^w_word;
`endif
            r_state     <= ST_FULL;
          end
        end

        ST_FULL: begin
          // Flush cannot drop a completed word; it only holds off input.
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_count <= r_out_count + 8'd1;
            if (w_in_fire) begin
              r_lo    <= bus.in_data;
              r_state <= ST_HAVE_LO;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
`ifdef PACKER_PARITY_EN
  assign bus.out_parity = r_out_parity;
`endif

endmodule

// File: tb/tb_halfword_packer.sv
// Self-checking bench for halfword_packer: directed cases plus randomized traffic
// compared every cycle against a queue-based model of the pairing rules.
module tb_halfword_packer;

  logic clk;
  logic rst_n;
  logic flush;

  halfword_packer_if #(.HALF_W(16)) bus ();

  halfword_packer #(.HALF_W(16)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .flush   (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: halfwords accepted since the last completed pair, words awaiting the consumer,
  // and the number of words delivered since reset.
  logic [15:0] m_halves[$];
  logic [31:0] m_words[$];
  int          m_count = 0;

  always @(negedge rst_n) begin
    m_halves.delete();
    m_words.delete();
    m_count = 0;
  end

  // Outputs are stable at the falling edge; inputs stay put until after the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic exp_in_ready;
      logic in_fire;
      logic out_fire;
      exp_in_ready = !flush && (m_words.size() == 0 || bus.out_ready);
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_words.size() != 0});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_in_ready});
      check("out_count", {24'd0, bus.out_count}, 32'(m_count % 256));
      if (m_words.size() != 0) begin
        check("out_data", bus.out_data, m_words[0]);
`ifdef PACKER_PARITY_EN
        check("out_parity", {31'd0, bus.out_parity}, {31'd0, ^m_words[0]});
`endif
      end
      in_fire  = bus.in_valid && exp_in_ready;
      out_fire = (m_words.size() != 0) && bus.out_ready;
      if (out_fire) begin
        void'(m_words.pop_front());
        m_count++;
      end
      if (flush) m_halves.delete();
      if (in_fire) begin
        m_halves.push_back(bus.in_data);
        if (m_halves.size() == 2) begin
          m_words.push_back({m_halves[1], m_halves[0]});
          m_halves.delete();
        end
      end
    end
  end

  // Inputs change just after a rising edge; the next rising edge consumes them.
  task automatic step(input logic v, input logic [15:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_count", {24'd0, bus.out_count}, 32'd0);
`ifdef PACKER_PARITY_EN
    check("rst_out_parity", {31'd0, bus.out_parity}, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Basic pair
    step(1'b1, 16'h4321, 1'b1, 1'b0);
    step(1'b1, 16'h8765, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("pair_valid", {31'd0, bus.out_valid}, 32'd1);
    check("pair_data", bus.out_data, 32'h87654321);
    check("pair_count0", {24'd0, bus.out_count}, 32'd0);
`ifdef PACKER_PARITY_EN
    check("pair_parity", {31'd0, bus.out_parity}, 32'd1);
`endif
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("pair_count1", {24'd0, bus.out_count}, 32'd1);
    check("pair_drained", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: offered input must be refused while the word waits
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h5555, 1'b0, 1'b0);
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_data", bus.out_data, 32'hFFFF0001);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("bp_count", {24'd0, bus.out_count}, 32'd2);
    check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

    // Flush discards the held low half; flush also beats a simultaneous in_valid
    step(1'b1, 16'hAAAA, 1'b1, 1'b0);
    step(1'b1, 16'hBBBB, 1'b1, 1'b1);
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step(1'b1, 16'h1111, 1'b1, 1'b0);
    step(1'b1, 16'h2222, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("flush_data", bus.out_data, 32'h22221111);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("flush_count", {24'd0, bus.out_count}, 32'd3);

    // Back-to-back stream of 8 halfwords: input never stalls
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'(16'h1000 + i), 1'b1, 1'b0);
      check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("stream_count", {24'd0, bus.out_count}, 32'd7);

    // Reset mid-operation with a word held
    step(1'b1, 16'hCAFE, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_count", {24'd0, bus.out_count}, 32'd0);
    #1 rst_n = 1'b1;
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    step(1'b1, 16'hA5A5, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("post_rst_data", bus.out_data, 32'hA5A55A5A);
`ifdef PACKER_PARITY_EN
    check("post_rst_parity", {31'd0, bus.out_parity}, 32'd0);
`endif
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("post_rst_count", {24'd0, bus.out_count}, 32'd1);

    // Counter wrap: clean reset, then 256 words
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 510; i++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("wrap_255", {24'd0, bus.out_count}, 32'd255);
    step(1'b1, 16'($urandom), 1'b1, 1'b0);
    step(1'b1, 16'($urandom), 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("wrap_0", {24'd0, bus.out_count}, 32'd0);

    // Randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
